// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the configurable UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StPar   = 3'd3,
    StStop  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge detector on the
// synchronised signal.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All flops reset high so a line idling high never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, frame-error
// detection and a one-cycle completion pulse with registered status.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT  = 56,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = $clog2(BAUD_CNT + 1);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntHalf = CNT_W'(BAUD_CNT / 2);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(BAUD_CNT);
  localparam logic [BIT_W-1:0] BitLast = BIT_W'(DATA_BITS - 1);

  logic line;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (rs232_rx),
    .dout (line),
    .fall (fall)
  );

  rx_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [DATA_BITS-1:0]  shift_nxt;
  logic                  par_q;
  logic                  wait_high_q;
  logic                  par_xor;

  always_comb begin
    shift_nxt = shift_q;
    if (MSB_FIRST != 0) begin
      shift_nxt = {shift_q[DATA_BITS-2:0], line};
    end else begin
      shift_nxt = {line, shift_q[DATA_BITS-1:1]};
    end
  end

  assign par_xor = ^{shift_q, par_q};

  // cnt_q equals the number of cycles since the frame (or last sample) began,
  // so sample points are simple equality compares against constants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wait_high_q <= 1'b0;
      rx_data     <= '0;
      po_flag     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      po_flag    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (line) begin
            wait_high_q <= 1'b0;
          end
          if (fall && !wait_high_q) begin
            state_q <= StStart;
            cnt_q   <= CntOne;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            bit_q <= '0;
            if (line) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              state_q <= StData;
              cnt_q   <= CntOne;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= CntOne;
            shift_q <= shift_nxt;
            if (bit_q == BitLast) begin
              state_q <= (PARITY != PAR_NONE) ? StPar : StStop;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPar: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= CntOne;
            par_q   <= line;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_data     <= shift_q;
            po_flag     <= 1'b1;
            frame_err   <= ~line;
            wait_high_q <= ~line;
            if (PARITY == PAR_ODD) begin
              parity_err <= ~par_xor;
            end else if (PARITY != PAR_NONE) begin
              parity_err <= par_xor;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter BAUD_CNT, default 56: clk cycles per bit (560 ns at 100 MHz); legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter MSB_FIRST, default 1: 1 = first data bit on the line is rx_data MSB; 0 = LSB first.
REQ-004 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 rs232_rx  in  1  asynchronous serial line, idle high.
REQ-008 rx_data  out  DATA_BITS  last received data word, held until next frame completes.
REQ-009 po_flag  out  1  one-cycle pulse per completed frame.
REQ-010 parity_err  out  1  parity mismatch; valid only while po_flag=1, else 0.
REQ-011 frame_err  out  1  stop bit sampled low; valid only while po_flag=1, else 0.

Function
REQ-012 rs232_rx SHALL pass a 2-flop synchroniser; all decoding uses the synchronised signal.
REQ-013 States SHALL be IDLE, START, DATA, PAR, STOP.
REQ-014 IDLE -> START on a synchronised 1->0 transition; the edge-detect cycle is cycle 0 of the frame.
REQ-015 The start bit SHALL be sampled at cycle BAUD_CNT/2 (integer divide); sampled 1 -> return to IDLE, no outputs change (glitch rejection).
REQ-016 Data bit k (k=0..DATA_BITS-1) SHALL be sampled at cycle BAUD_CNT/2 + (k+1)*BAUD_CNT.
REQ-017 With MSB_FIRST=1, bit k lands in rx_data[DATA_BITS-1-k]; with 0, in rx_data[k].
REQ-018 PAR state exists only when PARITY!=0; parity bit sampled one BAUD_CNT after the last data bit.
REQ-019 Odd: XOR of data and parity bits SHALL equal 1; even: SHALL equal 0; otherwise parity_err=1.
REQ-020 Stop bit sampled one BAUD_CNT after the last data/parity bit; sampled 0 -> frame_err=1.
REQ-021 On the cycle after the stop sample: rx_data updated, po_flag=1, error flags valid, state -> IDLE.
REQ-022 rx_data SHALL be updated even when parity_err or frame_err is set.
REQ-023 After a frame error the FSM SHALL NOT start a new frame until the synchronised line has been seen high at least once.
REQ-024 Line activity during a frame (other than at sample points) SHALL be ignored; no early abort.
REQ-025 Back-to-back frames (start edge immediately after a valid stop half-bit) SHALL be received without loss.
REQ-026 Baud counter and bit counter widths SHALL be derived with $clog2 from BAUD_CNT and DATA_BITS; no wrap before the terminal count.

Reset
REQ-027 While rst_n=0 at a clk edge: state IDLE, counters 0, synchroniser flops 1, rx_data 0, po_flag 0, parity_err 0, frame_err 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no po_flag; reception resumes on the next falling edge after release.

Structure
REQ-029 Package uart_pkg SHALL hold parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) and the FSM state encoding.
REQ-030 One sub-module uart_rx_sync SHALL hold the 2-flop synchroniser plus falling-edge detector.

Verification (defaults unless stated; 10 ns clock)
REQ-031 Frame 0xA5 MSB-first, 560 ns bits, stop=1 -> exactly one po_flag, rx_data=8'hA5, both errors 0.
REQ-032 Four consecutive frames 0x12,0x34,0x56,0x78 back-to-back -> four po_flag pulses with those values in order.
REQ-033 Line low for 20 cycles then high -> no po_flag, rx_data unchanged.
REQ-034 Frame 0x3C with stop bit 0 -> po_flag=1 with frame_err=1, rx_data=8'h3C; no new frame until line returns high.
REQ-035 PARITY=2, MSB_FIRST=0, DATA_BITS=7, data 7'h55 with parity bit 1 -> po_flag, rx_data=7'h55, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-036 rst_n low for 3 cycles during data bit 4 -> no po_flag; next frame 0xC3 received correctly.
